// File: rtl/axis_downsizer_n_pkg.sv
// Shared helpers for the AXI-Stream downsizer: tkeep lane counting and legality.
package axis_pkg;

    // Widest ratio the keep helpers handle; callers zero-extend narrower masks.
    localparam int unsigned KEEP_MAX_N = 16;

    // Number of set lanes among the low n bits of keep.
    function automatic int unsigned keep_count(input logic [KEEP_MAX_N-1:0] keep,
                                               input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < KEEP_MAX_N; i++) begin
            if ((i < n) && keep[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    // Legal masks are nonzero and packed against the MSB lane n-1.
    function automatic logic keep_legal(input logic [KEEP_MAX_N-1:0] keep,
                                        input int unsigned n);
        int unsigned k;
        logic        ok;
        k  = keep_count(keep, n);
        ok = (k != 0);
        for (int unsigned i = 0; i < KEEP_MAX_N; i++) begin
            if (i < n) begin
                if (keep[i] != (i >= (n - k))) begin
                    ok = 1'b0;
                end
            end else if (keep[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/axis_downsizer_n.sv
// N:1 AXI-Stream width downsizer; emits lanes MSB-first, skips trailing
// unkept lanes, forwards tlast on the final kept lane. Supports N up to 16.
module axis_downsizer_n
    import axis_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [N*W-1:0] in_tdata,
    input  logic [N-1:0]   in_tkeep,
    input  logic           in_tlast,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [W-1:0]   out_tdata,
    output logic           out_tlast,
    output logic           out_tvalid,
    input  logic           out_tready
);

    localparam int unsigned LW = $clog2(N + 1);

    logic [N*W-1:0] buf_q, buf_d;
    logic [LW-1:0]  lanes_left_q, lanes_left_d;
    logic           last_q, last_d;
    logic [W-1:0]   out_tdata_q, out_tdata_d;
    logic           out_tlast_q, out_tlast_d;
    logic           out_tvalid_q, out_tvalid_d;

    logic [LW-1:0]  keep_k;
    logic           in_hs;
    logic           out_hs;

    assign keep_k = LW'(keep_count(KEEP_MAX_N'(in_tkeep), N));

    // Accept a new beat only once the buffer is empty and the output slot frees up.
    assign in_tready = ~areset & (lanes_left_q == '0) & (~out_tvalid_q | out_tready);
    assign in_hs     = in_tvalid & in_tready;
    assign out_hs    = out_tvalid_q & out_tready;

    assign out_tdata  = out_tdata_q;
    assign out_tlast  = out_tlast_q;
    assign out_tvalid = out_tvalid_q;

    // Next-state: load takes priority so the final lane and next beat share one edge.
    always_comb begin
        buf_d        = buf_q;
        lanes_left_d = lanes_left_q;
        last_d       = last_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        out_tvalid_d = out_tvalid_q;
        if (in_hs) begin
            out_tdata_d  = in_tdata[N*W-1 -: W];
            out_tlast_d  = in_tlast & (keep_k == LW'(1));
            out_tvalid_d = 1'b1;
            buf_d        = in_tdata << W;
            lanes_left_d = keep_k - 1'b1;
            last_d       = in_tlast;
        end else if (out_hs) begin
            if (lanes_left_q != '0) begin
                out_tdata_d  = buf_q[N*W-1 -: W];
                out_tlast_d  = last_q & (lanes_left_q == LW'(1));
                buf_d        = buf_q << W;
                lanes_left_d = lanes_left_q - 1'b1;
            end else begin
                out_tvalid_d = 1'b0;
            end
        end
    end

    // State and output registers; reset drops any partially sent beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            buf_q        <= '0;
            lanes_left_q <= '0;
            last_q       <= 1'b0;
            out_tdata_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            lanes_left_q <= lanes_left_d;
            last_q       <= last_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
            out_tvalid_q <= out_tvalid_d;
        end
    end

`ifndef SYNTHESIS
    a_stall_stable: assert property (@(posedge aclk) disable iff (areset)
        (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata) && $stable(out_tlast)));

    a_keep_legal: assert property (@(posedge aclk) disable iff (areset)
        in_hs |-> keep_legal(KEEP_MAX_N'(in_tkeep), N));

    a_last_final_lane: assert property (@(posedge aclk) disable iff (areset)
        (out_tvalid && out_tlast) |-> (lanes_left_q == '0));
`endif

endmodule

// File: tb/tb_axis_downsizer_n.sv
// Self-checking bench for axis_downsizer_n (N=4, W=8) against a lane-queue model.
module tb_axis_downsizer_n;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           aclk = 1'b0;
    logic           areset;
    logic [N*W-1:0] in_tdata;
    logic [N-1:0]   in_tkeep;
    logic           in_tlast;
    logic           in_tvalid;
    logic           in_tready;
    logic [W-1:0]   out_tdata;
    logic           out_tlast;
    logic           out_tvalid;
    logic           out_tready;

    always #5 aclk = ~aclk;

    axis_downsizer_n #(.W(W), .N(N)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    // Model: every accepted-but-unconsumed lane as {last, data}, front = on the bus.
    logic [W:0]   exp_q[$];
    logic [W-1:0] log_q[$];
    int unsigned  log_cyc[$];
    int unsigned  acc_cyc[$];

    bit           stall_prev = 1'b0;
    bit           rand_rdy   = 1'b0;
    bit           hs_seen    = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        model_rdy;
        int unsigned k;
        logic [W:0]  front;
        if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
        hs_seen = 1'b0;
        @(negedge aclk);
        if (areset) begin
            chk("ready_in_reset", 32'(in_tready), 32'd0);
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("out_tvalid", 32'(out_tvalid), 32'(exp_q.size() != 0));
            model_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && out_tready);
            chk("in_tready", 32'(in_tready), 32'(model_rdy));
            if (stall_prev) begin
                chk("stall_tdata", 32'(out_tdata), 32'(prev_d));
                chk("stall_tlast", 32'(out_tlast), 32'(prev_l));
            end
            if (out_tvalid && out_tready && (exp_q.size() != 0)) begin
                front = exp_q.pop_front();
                chk("out_tdata", 32'(out_tdata), 32'(front[W-1:0]));
                chk("out_tlast", 32'(out_tlast), 32'(front[W]));
                log_q.push_back(out_tdata);
                log_cyc.push_back(cyc);
            end
            if (in_tvalid && in_tready) begin
                hs_seen = 1'b1;
                acc_cyc.push_back(cyc);
                k = 0;
                for (int i = 0; i < int'(N); i++) if (in_tkeep[i]) k++;
                for (int i = N - 1; i >= int'(N - k); i--)
                    exp_q.push_back({in_tlast && (i == int'(N - k)), in_tdata[i*W +: W]});
            end
            stall_prev = out_tvalid && !out_tready;
            prev_d     = out_tdata;
            prev_l     = out_tlast;
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // Present a beat and hold it until accepted; in_tvalid stays high afterwards.
    task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
        int unsigned n;
        n         = 0;
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_tvalid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!hs_seen && n < 50);
        chk("send_accept", 32'(hs_seen), 32'd1);
    endtask

    task automatic drain();
        int unsigned n;
        n         = 0;
        in_tvalid = 1'b0;
        while (((exp_q.size() != 0) || out_tvalid) && n < 80) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        cycle();
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        logic [N*W-1:0] d0;
        logic [N*W-1:0] d1;
        logic [W-1:0]   e1[4];
        int unsigned    n;

        areset     = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
        @(posedge aclk);
        #1;
        cycle();
        cycle();
        areset = 1'b0;
        chk("reset_tvalid", 32'(out_tvalid), 32'd0);
        chk("reset_tdata",  32'(out_tdata),  32'd0);
        chk("reset_tlast",  32'(out_tlast),  32'd0);
        cycle();

        // Full keep, no stall.
        clear_logs();
        send(32'hA1B2C3D4, 4'hF, 1'b1);
        drain();
        e1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        chk("t1_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_lane", 32'(log_q[i]), 32'(e1[i]));
        chk("t1_latency", log_cyc[0], acc_cyc[0] + 1);
        chk("t1_contig", log_cyc[3], log_cyc[0] + 3);

        // Back-to-back full beats.
        clear_logs();
        for (int b = 0; b < 3; b++) send($urandom, 4'hF, 1'(b == 2));
        drain();
        chk("t2_count", 32'(log_q.size()), 32'd12);
        chk("t2_contig", log_cyc[11], log_cyc[0] + 11);
        chk("t2_acc1", acc_cyc[1], acc_cyc[0] + 4);
        chk("t2_acc2", acc_cyc[2], acc_cyc[1] + 4);

        // Partial keep followed immediately by another beat.
        clear_logs();
        send(32'h11223344, 4'hC, 1'b1);
        send($urandom, 4'hF, 1'b1);
        drain();
        chk("t3_count", 32'(log_q.size()), 32'd6);
        chk("t3_lane0", 32'(log_q[0]), 32'h11);
        chk("t3_lane1", 32'(log_q[1]), 32'h22);
        chk("t3_acc", acc_cyc[1], acc_cyc[0] + 2);

        // Random output stalls across a 2-beat packet.
        clear_logs();
        d0       = $urandom;
        d1       = $urandom;
        rand_rdy = 1'b1;
        send(d0, 4'hF, 1'b0);
        send(d1, 4'hF, 1'b1);
        drain();
        rand_rdy   = 1'b0;
        out_tready = 1'b1;
        chk("t4_count", 32'(log_q.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            logic [N*W-1:0] dd;
            dd = (j < 4) ? d0 : d1;
            chk("t4_lane", 32'(log_q[j]), 32'(dd[(3 - (j % 4))*W +: W]));
        end

        // Single-lane beats.
        clear_logs();
        for (int i = 0; i < 5; i++) send($urandom, 4'h8, 1'(i == 4));
        drain();
        chk("t5_count", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 4; i++) chk("t5_acc", acc_cyc[i+1], acc_cyc[i] + 1);
        chk("t5_contig", log_cyc[4], log_cyc[0] + 4);

        // Reset after two of four lanes have been sent.
        clear_logs();
        send($urandom, 4'hF, 1'b1);
        in_tvalid = 1'b0;
        n = 0;
        while (log_q.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_two_sent", 32'(log_q.size()), 32'd2);
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        chk("t6_valid_after_reset", 32'(out_tvalid), 32'd0);
        clear_logs();
        d1 = $urandom;
        send(d1, 4'hF, 1'b1);
        drain();
        chk("t6_count", 32'(log_q.size()), 32'd4);
        chk("t6_first", 32'(log_q[0]), 32'(d1[N*W-1 -: W]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_downsizer_n.md
# axis_downsizer_n

Parametrised N:1 AXI-Stream width downsizer: accepts one N*W-bit input beat and emits its lanes as up to N consecutive W-bit output beats, most-significant lane first. It generalises the fixed 2:1 downsizer with an arbitrary ratio, per-lane `tkeep` (skipping trailing empty lanes) and `tlast` propagation, at full throughput with no bubble between input beats. It sits between a wide datapath, such as a DMA read or a wide FIFO, and a narrow AXI-Stream consumer.

## Interface
- `W`, 32: output lane width in bits, ≥1.
- `N`, 4: ratio (lanes per input beat), ≥2.
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `in_tdata`  in  N*W  lane i = bits [i*W +: W]; lane N-1 is sent first.
- `in_tkeep`  in  N  bit i marks lane i valid.
- `in_tlast`  in  1  packet end.
- `in_tvalid`  in  1.
- `in_tready`  out  1.
- `out_tdata`  out  W.
- `out_tlast`  out  1.
- `out_tvalid`  out  1.
- `out_tready`  in  1.

## Operation
- **`in_tkeep` legality:**
  - `in_tkeep` must be nonzero and contiguous from the MSB: lanes N-1 down to N-k are set, where k is 1..N.
  - Any other pattern is undefined behaviour.
  - The bench never drives illegal patterns; an SVA flags them.
- **State:**
  - Holding register `buf` (N*W bits), captured on input handshake.
  - `lanes_left`, $clog2(N+1) bits; 0 means empty.
  - `last_q`, holding the captured `in_tlast`.
- **Load:** on an input handshake:
  - `lanes_left` ← k-1 (the first lane goes directly to the output register).
  - `out_tdata` ← lane N-1.
  - `out_tlast` ← `in_tlast` & (k==1).
  - `out_tvalid` ← 1.
  - `buf` ← `in_tdata` shifted up one lane.
- **Advance:** on an output handshake with `lanes_left`>0:
  - `out_tdata` ← top lane of `buf`.
  - `buf` shifts up one lane.
  - `lanes_left` decrements.
  - `out_tlast` ← `last_q` & (`lanes_left`==1).
- **Drain:** on an output handshake with `lanes_left`==0 and no input handshake, `out_tvalid` ← 0.
- **`in_tready`** = (`lanes_left`==0) & (~`out_tvalid` | `out_tready`).
  - Combinational from `out_tready`; no path from `in_tvalid`.
- **Stall:** while `out_tvalid` & ~`out_tready`:
  - `out_tdata`, `out_tlast` and `out_tvalid` are held unchanged (AXI stability).
  - `buf` and `lanes_left` are frozen.
- **Simultaneous events:** an output handshake on the final lane of a beat together with an input handshake loads the next beat in the same edge. There is no idle cycle.
- **Reset** (at any time, including mid-beat):
  - `out_tvalid`=0, `out_tlast`=0, `out_tdata`=0, `lanes_left`=0, `last_q`=0.
  - Partially sent lanes are discarded.
  - `in_tready` is 0 while `areset` is high.

## Timing
- **Latency:** an input handshake at edge t gives the first lane on `out_*` from cycle t+1.
- **Throughput:** with `out_tready` held at 1, one W-bit beat is emitted per cycle.
  - A full-keep stream sustains 1 input beat per N cycles.
  - A k-lane beat occupies k cycles.
- **Registered outputs:** `out_tdata`, `out_tlast` and `out_tvalid` come straight from flops.
  - `in_tready` is the only combinational output.
- **Back-pressure:** while the block is stalled, `in_tready` stays 0 and `in_tdata` may change freely without effect.

## Structure
- **Package `axis_pkg`:**
  - Function `keep_count(logic [N-1:0])` returning k. It is parametrised via a parametrised class static function, or written generically up to a documented max N of 16.
  - Function `keep_legal()` for the SVA.
- **Sub-module:** none required.
  - Lane selection is a fixed shift, not a mux tree.
  - The `keep_count` logic stays inline through the package function.
- **Assertions:** bound in the same file under `ifdef` guard.
  - Output stability under stall.
  - `in_tkeep` legality on input handshake.
  - `out_tlast` only ever set on the final lane of a beat.

## Test plan
- **Full-keep, no stall:** N=4, W=8, one beat `in_tdata`=32'hA1B2C3D4, `in_tkeep`=4'hF, `in_tlast`=1, `out_tready`=1 → outputs A1,B2,C3,D4 on consecutive cycles starting t+1, `out_tlast` only on D4, `in_tready` high again in the D4 cycle.
- **Back-to-back:** 3 full beats streamed with `in_tvalid` held high → 12 contiguous output beats, no gap, `in_tready` pulses once every 4 cycles.
- **Partial keep:** beat 32'h11223344 with `in_tkeep`=4'hC and `in_tlast`=1 → outputs 11, 22 with `out_tlast` on 22; lanes 33 and 44 are never emitted; next beat is accepted in the 22 cycle.
- **Random stall:** `out_tready` toggled randomly during a 2-beat packet → output sequence identical to the no-stall case, `out_tdata` and `out_tlast` stable whenever valid & ~ready, no duplicated or lost lanes.
- **Single-lane beats:** `in_tkeep`=4'h8 repeated 5 times → 5 output beats at 1 per cycle, `in_tready` continuously high under `out_tready`=1.
- **Reset mid-beat:** `areset` asserted for 1 cycle after 2 of 4 lanes are sent → `out_tvalid`=0 the next cycle, remaining lanes dropped, first beat after reset starts at lane N-1 of new data.
